rom_boot_copier: RTL and testbench

//  Sequences a BAREROM read port and a BARERAM write port to copy a block of words

---
 rtl/rom_boot_copier_pkg.sv | 10 +
 rtl/rom_boot_copier.sv | 108 ++++++++++
 tb/tb_rom_boot_copier.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_boot_copier_pkg.sv
// Shared definitions for the ROM-to-RAM boot copier: FSM state encodings,
// visible to the copier and to anything that needs to decode its state by name.
package rom_boot_copier_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COPY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/rom_boot_copier.sv
// Copies a block of words from a 1-cycle-latency ROM read port into a RAM write
// port, one word per cycle, holding the core off while the copy runs.
module rom_boot_copier
    import rom_boot_copier_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SCALE  = 10,
    parameter int DSCALE = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [SCALE-1:0]  src_base_i,
    input  logic [DSCALE-1:0] dst_base_i,
    input  logic [SCALE:0]    count_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cpu_hold_o,
    output logic              rom_oe_o,
    output logic [SCALE-1:0]  rom_addr_o,
    input  logic [WIDTH-1:0]  rom_rdata_i,
    output logic              ram_we_o,
    output logic [DSCALE-1:0] ram_addr_o,
    output logic [WIDTH-1:0]  ram_wdata_o
);

    localparam logic [SCALE:0]    REM_ONE = (SCALE + 1)'(1);
    localparam logic [SCALE-1:0]  SRC_ONE = SCALE'(1);
    localparam logic [DSCALE-1:0] DST_ONE = DSCALE'(1);

    logic [1:0]        state_q, state_d;
    logic [SCALE-1:0]  src_ptr_q, src_ptr_d;
    logic [DSCALE-1:0] dst_ptr_q, dst_ptr_d;
    logic [SCALE:0]    remaining_q, remaining_d;
    logic              wr_v_q;
    logic              accept;
    logic              rd_issue;

    assign accept   = (state_q == ST_IDLE) && start_i;
    assign rd_issue = (state_q == ST_COPY) && !hold_i;

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_ptr_d   = src_base_i;
                    remaining_d = count_i;
                    state_d     = (count_i == '0) ? ST_FIN : ST_COPY;
                end
            end
            ST_COPY: begin
                if (!hold_i) begin
                    src_ptr_d   = src_ptr_q + SRC_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last read's data lands this cycle; its write closes the copy.
                if (wr_v_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Write pointer follows the write pipe, never the read side, so hold cannot skew it.
        if (accept) begin
            dst_ptr_d = dst_base_i;
        end else if (wr_v_q) begin
            dst_ptr_d = dst_ptr_q + DST_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            wr_v_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            wr_v_q      <= rd_issue;
        end
    end

    assign busy_o      = (state_q == ST_COPY) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_FIN);
    assign cpu_hold_o  = busy_o || accept;
    assign rom_oe_o    = rd_issue;
    assign rom_addr_o  = src_ptr_q;
    assign ram_we_o    = wr_v_q;
    assign ram_addr_o  = dst_ptr_q;
    assign ram_wdata_o = rom_rdata_i;

endmodule

// File: tb/tb_rom_boot_copier.sv
// Bench for rom_boot_copier: behavioural ROM/RAM around the copier, a table of
// copy jobs with hand-computed timing, plus a hand-written mid-copy reset sequence.
module tb_rom_boot_copier;
    import rom_boot_copier_pkg::*;

    localparam int WORDS = 1024;

    typedef struct {
        int          src;
        int          dst;
        int          cnt;
        logic [63:0] hold_mask;
        logic [63:0] restart_mask;
        int          exp_done;
        int          exp_first_wr;
        int          exp_last_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  src_base;
    logic [9:0]  dst_base;
    logic [10:0] count;
    logic        hold;
    logic        busy, done, cpu_hold, rom_oe, ram_we;
    logic [9:0]  rom_addr, ram_addr;
    logic [31:0] rom_rdata, ram_wdata;
    logic        clr_ram;

    logic [31:0] rom_mem [WORDS];
    logic [31:0] ram_mem [WORDS];

    int checks = 0;
    int errors = 0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_oe) rom_rdata <= rom_mem[rom_addr];
    end

    always @(posedge clk) begin
        if (clr_ram) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= 32'h0;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end

    rom_boot_copier #(.WIDTH(32), .SCALE(10), .DSCALE(10)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .src_base_i  (src_base),
        .dst_base_i  (dst_base),
        .count_i     (count),
        .hold_i      (hold),
        .busy_o      (busy),
        .done_o      (done),
        .cpu_hold_o  (cpu_hold),
        .rom_oe_o    (rom_oe),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_ram();
        clr_ram = 1'b1;
        @(posedge clk);
        #1;
        clr_ram = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int rd_n, wr_n, first_wr, last_wr, done_cnt, done_cyc, stray;
        rd_n = 0; wr_n = 0; first_wr = -1; last_wr = -1;
        done_cnt = 0; done_cyc = -1; stray = 0;
        clear_ram();
        src_base = 10'(v.src);
        dst_base = 10'(v.dst);
        count    = 11'(v.cnt);
        start    = 1'b1;
        hold     = v.hold_mask[0];
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (c == 0) chk("cpu_hold_accept", 32'(cpu_hold), 32'd1);
            if ((rom_oe || ram_we) && !busy) stray++;
            if (rom_oe) begin
                chk("rd_addr", 32'(rom_addr), 32'((v.src + rd_n) % WORDS));
                rd_n++;
            end
            if (ram_we) begin
                chk("wr_addr", 32'(ram_addr), 32'((v.dst + wr_n) % WORDS));
                chk("wr_data", ram_wdata, 32'h0000A000 + 32'((v.src + wr_n) % WORDS));
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                wr_n++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk("state_at_done", 32'(dut.state_q), 32'(ST_FIN));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            start = (c + 1 < 64) ? v.restart_mask[c + 1] : 1'b0;
            hold  = (c + 1 < 64) ? v.hold_mask[c + 1] : 1'b0;
            if (start) begin
                src_base = 10'd500;
                dst_base = 10'd700;
                count    = 11'd7;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
        hold  = 1'b0;
        if (done_cyc < 0) $display("FAIL timeout vec%0d actual=no_done required=done", id);
        chk("done_cycle", done_cyc, v.exp_done);
        chk("done_count", done_cnt, 32'd1);
        chk("reads", rd_n, v.cnt);
        chk("writes", wr_n, v.cnt);
        chk("first_wr_cycle", first_wr, v.exp_first_wr);
        chk("last_wr_cycle", last_wr, v.exp_last_wr);
        chk("stray_strobes", stray, 32'd0);
        if (v.cnt > 0) begin
            chk("ram_first", ram_mem[v.dst % WORDS], 32'h0000A000 + 32'(v.src % WORDS));
            chk("ram_last", ram_mem[(v.dst + v.cnt - 1) % WORDS],
                32'h0000A000 + 32'((v.src + v.cnt - 1) % WORDS));
        end
        if (v.cnt < WORDS) chk("ram_beyond", ram_mem[(v.dst + v.cnt) % WORDS], 32'h0);
        $display("vec%0d src=%0d dst=%0d cnt=%0d reads=%0d writes=%0d done_cycle=%0d",
                 id, v.src, v.dst, v.cnt, rd_n, wr_n, done_cyc);
    endtask

    initial begin
        int dn;
        vec_t vr;
        //                src   dst    cnt   hold        restart     done  fw  lw
        vecs[0] = '{0,    16,    4,    64'h0,      64'h0,      6,    2,  5};
        vecs[1] = '{5,    5,     0,    64'h0,      64'h0,      1,    -1, -1};
        vecs[2] = '{32,   64,    6,    64'hC,      64'h0,      10,   2,  9};
        vecs[3] = '{48,   128,   4,    64'h0,      64'hE,      6,    2,  5};
        vecs[4] = '{1022, 1023,  4,    64'h0,      64'h0,      6,    2,  5};
        vecs[5] = '{7,    512,   1,    64'h0,      64'h0,      3,    2,  2};
        vecs[6] = '{9,    528,   2,    64'h2,      64'h0,      5,    3,  4};
        vecs[7] = '{9,    544,   2,    64'h19,     64'h0,      4,    2,  3};
        vecs[8] = '{100,  50,    1024, 64'h0,      64'h0,      1026, 2,  1025};

        for (int i = 0; i < WORDS; i++) rom_mem[i] = 32'h0000A000 + 32'(i);
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; clr_ram = 1'b0;
        src_base = '0; dst_base = '0; count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_rom_oe", 32'(rom_oe), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset asserted in cycle 3 of an 8-word copy, then a clean re-run.
        clear_ram();
        src_base = 10'd0; dst_base = 10'h300; count = 11'd8; start = 1'b1; hold = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("abort_rom_oe", 32'(rom_oe), 32'd0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_rom_addr", 32'(rom_addr), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 32'd0);
        chk("abort_ram_partial", ram_mem[10'h300], 32'h0000A000);
        chk("abort_ram_unwritten", ram_mem[10'h301], 32'h0);
        $display("abort src=0 dst=768 cnt=8 reset_cycle=3 done_seen=%0d", dn);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vr = '{0, 768, 8, 64'h0, 64'h0, 10, 2, 9};
        run_vec(9, vr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
